// File: rtl/score_keeper.sv
// score_keeper: turns line-clear events into level-weighted points and rolls the
// displayed score up one point per tick. It also keeps the cleared-line total and
// the level.
//
// Ports:
//   frame_clk      in   sole clock
//   Reset_n        in   asynchronous active-low reset
//   game_start     in   pulse: zero all state and enter RUN
//   game_over      in   pulse: stop accepting clears, drain pending points, then freeze
//   clear_valid    in   a clear event is offered
//   clear_count    in   lines cleared by the event (5..7 are treated as 4)
//   clear_ready    out  the event is accepted on an edge where valid && ready
//   score          out  displayed score, 0..SCORE_MAX
//   lines          out  total cleared lines, saturates at 999
//   level          out  current level, 0..MAX_LEVEL
//   busy           out  points are still pending
//   score_max_hit  out  sticky flag: score reached SCORE_MAX
module score_keeper #(
    parameter int unsigned TICK_DIV        = 2,
    parameter int unsigned SCORE_MAX       = 999,
    parameter int unsigned LINES_PER_LEVEL = 10,
    parameter int unsigned MAX_LEVEL       = 9
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       game_start,
    input  logic       game_over,
    input  logic       clear_valid,
    input  logic [2:0] clear_count,
    output logic       clear_ready,
    output logic [9:0] score,
    output logic [9:0] lines,
    output logic [3:0] level,
    output logic       busy,
    output logic       score_max_hit
);

    localparam int unsigned DIV_W       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    // Room for (LINES_PER_LEVEL-1) + 4 before the wrap.
    localparam int unsigned LVL_W       = $clog2(LINES_PER_LEVEL + 4);
    localparam int unsigned LINES_CAP   = 999;
    // Worst case is 175 + 80 = 255, so the 8-bit pending count cannot overflow.
    localparam int unsigned READY_LIMIT = 175;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    state_t             state, state_n;
    logic [7:0]         pending, pending_n;
    logic [DIV_W-1:0]   divider, divider_n;
    logic [LVL_W-1:0]   lvl_lines, lvl_lines_n;
    logic [9:0]         score_n, lines_n;
    logic [3:0]         level_n;
    logic               max_hit_n, ready_n, busy_n;

    logic [2:0]         n_sat;
    logic [7:0]         base_pts, lvl_mult, pts;
    logic [10:0]        lines_sum;
    logic [LVL_W-1:0]   lvl_sum;
    logic [8:0]         pend_sum;
    logic               running, tick, accept;

    // Next-state and next-output computation.
    always_comb begin
        state_n     = state;
        pending_n   = pending;
        divider_n   = divider;
        lvl_lines_n = lvl_lines;
        score_n     = score;
        lines_n     = lines;
        level_n     = level;
        max_hit_n   = score_max_hit;
        tick        = 1'b0;
        accept      = 1'b0;
        lines_sum   = 11'(lines) + 11'(n_sat);
        lvl_sum     = lvl_lines + LVL_W'(n_sat);
        pend_sum    = 9'(pending);
        running     = (state == RUN) || (state == FLUSH);

        n_sat = (clear_count > 3'd4) ? 3'd4 : clear_count;
        case (n_sat)
            3'd1:    base_pts = 8'd1;
            3'd2:    base_pts = 8'd3;
            3'd3:    base_pts = 8'd5;
            3'd4:    base_pts = 8'd8;
            default: base_pts = 8'd0;
        endcase
        lvl_mult  = 8'(level) + 8'd1;
        pts       = base_pts * lvl_mult;
        lines_sum = 11'(lines) + 11'(n_sat);
        lvl_sum   = lvl_lines + LVL_W'(n_sat);

        if (game_start) begin
            // A restart wins over game_over and drops any same-cycle event.
            state_n     = RUN;
            pending_n   = 8'd0;
            divider_n   = '0;
            lvl_lines_n = '0;
            score_n     = 10'd0;
            lines_n     = 10'd0;
            level_n     = 4'd0;
            max_hit_n   = 1'b0;
        end else begin
            accept    = clear_valid && clear_ready;
            tick      = running && (divider == DIV_W'(TICK_DIV - 1));
            divider_n = (running && !tick) ? divider + DIV_W'(1) : '0;

            if (accept) begin
                lines_n = (lines_sum > 11'(LINES_CAP)) ? 10'(LINES_CAP) : 10'(lines_sum);
                if (lvl_sum >= LVL_W'(LINES_PER_LEVEL)) begin
                    lvl_lines_n = lvl_sum - LVL_W'(LINES_PER_LEVEL);
                    if (level < 4'(MAX_LEVEL)) begin
                        level_n = level + 4'd1;
                    end
                end else begin
                    lvl_lines_n = lvl_sum;
                end
                // Once the score has saturated, clears no longer add points.
                if (!score_max_hit) begin
                    pend_sum = pend_sum + 9'(pts);
                end
            end

            // The add and the tick fold into a single pending update.
            if (tick && (pending != 8'd0)) begin
                score_n  = score + 10'd1;
                pend_sum = pend_sum - 9'd1;
                if (score_n == 10'(SCORE_MAX)) begin
                    pend_sum  = 9'd0;
                    max_hit_n = 1'b1;
                end
            end
            pending_n = 8'(pend_sum);

            case (state)
                RUN:     if (game_over) state_n = FLUSH;
                FLUSH:   if (pending == 8'd0) state_n = HALT;
                default: state_n = state;
            endcase
        end

        ready_n = (state_n == RUN) && (pending_n <= 8'(READY_LIMIT));
        busy_n  = (pending_n != 8'd0);
    end

    // State and output registers.
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            pending       <= 8'd0;
            divider       <= '0;
            lvl_lines     <= '0;
            score         <= 10'd0;
            lines         <= 10'd0;
            level         <= 4'd0;
            score_max_hit <= 1'b0;
            clear_ready   <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            pending       <= pending_n;
            divider       <= divider_n;
            lvl_lines     <= lvl_lines_n;
            score         <= score_n;
            lines         <= lines_n;
            level         <= level_n;
            score_max_hit <= max_hit_n;
            clear_ready   <= ready_n;
            busy          <= busy_n;
        end
    end

endmodule
